byte_packer: RTL and testbench



---
 rtl/byte_packer.sv | 151 +++++++++++++++
 tb/tb_byte_packer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
//   Collects a serial byte stream and assembles it into one word per four
//   accepted bytes. This is the reverse path of the word-to-byte splitter.
//   It sustains one byte per cycle and has a one-entry output buffer.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
//   valid & ready are both high. A producer holds valid and data stable until
//   that transfer. out_valid is never retracted before its word is taken.
//   in_ready is combinational and does not depend on in_valid.
//
// Parameters
//   BYTE_W    : width of one byte lane; the word is 4*BYTE_W bits wide.
//   MSB_FIRST : 1 = the first accepted byte lands in the top lane of out_data.
//               0 = the first accepted byte lands in the bottom lane.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_data    : byte from source
//   in_valid   : in_data valid
//   in_ready   : packer accepts in_data this cycle
//   out_data   : assembled word
//   out_valid  : out_data holds a complete word
//   out_ready  : consumer takes out_data this cycle
//   flush      : (BYTE_PACKER_FLUSH_EN only) force emit of a partial word
//   out_bytes  : (BYTE_PACKER_FLUSH_EN only) valid byte count in out_data
//
// Optional feature macro: BYTE_PACKER_FLUSH_EN
//   When defined, this adds the flush/out_bytes ports and the partial-word
//   emit logic. When undefined, none of that logic or those ports exist.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module byte_packer #(
  parameter int BYTE_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BYTE_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [4*BYTE_W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready
`ifdef BYTE_PACKER_FLUSH_EN
  ,
  input  logic                flush,
  output logic [2:0]          out_bytes
`endif
);

  localparam int WORD_W = 4 * BYTE_W;

  // Assembly state: lane counter and partially built word.
  logic [1:0]        cnt;
  logic [WORD_W-1:0] acc;

  logic              byte_acc;   // byte transfer this cycle
  logic              word_acc;   // word transfer this cycle
  logic              out_free;   // output buffer empty, or being emptied now
  logic              full_fire;  // fourth byte accepted -> full word emitted
  logic              emit;       // load out_data this cycle
  logic [1:0]        lane;       // physical lane written by the current byte
  logic [WORD_W-1:0] acc_next;   // acc with the incoming byte merged in

  assign byte_acc = in_valid & in_ready;
  assign word_acc = out_valid & out_ready;
  assign out_free = ~out_valid | out_ready;

  // Lane 3 is the top of the word. In MSB-first order, byte 0 goes to lane 3.
  assign lane = MSB_FIRST ? (2'd3 - cnt) : cnt;

  always_comb begin
    acc_next = acc;
    acc_next[lane*BYTE_W +: BYTE_W] = in_data;
  end

  assign full_fire = byte_acc & (cnt == 2'd3);

`ifdef BYTE_PACKER_FLUSH_EN
  // A flush request that cannot be emitted yet is latched in flush_pend.
  // While latched, the byte side is stalled, so the partial word cannot grow
  // past what the flush is meant to capture.
  logic flush_pend;
  logic flush_req;
  logic flush_blocked;
  logic flush_fire;

  assign flush_req     = flush | flush_pend;
  assign flush_blocked = flush_req & (cnt != 2'd0) & ~out_free;
  assign in_ready      = ((cnt != 2'd3) | out_free) & ~flush_blocked;
  // A byte accepted in the same cycle joins the flushed word.
  assign flush_fire    = flush_req & out_free & ((cnt != 2'd0) | byte_acc);
  assign emit          = full_fire | flush_fire;
`else
  // Only the fourth byte can stall, and only while an older word is still
  // unconsumed.
  assign in_ready = (cnt != 2'd3) | out_free;
  assign emit     = full_fire;
`endif

  // Accumulator and lane counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 2'd0;
      acc <= '0;
    end else if (emit) begin
      cnt <= 2'd0;
      acc <= '0;
    end else if (byte_acc) begin
      cnt <= cnt + 2'd1;
      acc <= acc_next;
    end
  end

  // Output buffer. A new word and a consumed word in the same cycle swap
  // directly with out_valid held high, so the output has no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (emit) begin
      out_data  <= byte_acc ? acc_next : acc;
      out_valid <= 1'b1;
    end else if (word_acc) begin
      out_valid <= 1'b0;
    end
  end

`ifdef BYTE_PACKER_FLUSH_EN
  // Byte count of the emitted word, and the held flush request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_bytes  <= 3'd0;
      flush_pend <= 1'b0;
    end else begin
      if (emit) begin
        out_bytes <= {1'b0, cnt} + {2'b00, byte_acc};
      end
      if (flush_fire) begin
        flush_pend <= 1'b0;
      end else if (flush_blocked) begin
        flush_pend <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_byte_packer.sv
`timescale 1ns/1ps

module tb_byte_packer;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 4 * BYTE_W;

  // ---------------------------------------------------------------- clock/reset
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [BYTE_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;

  logic              in_ready, in_ready_l;
  logic [WORD_W-1:0] out_data, out_data_l;
  logic              out_valid, out_valid_l;
`ifdef BYTE_PACKER_FLUSH_EN
  logic              flush = 1'b0;
  logic [2:0]        out_bytes, out_bytes_l;
`endif

  always #5 clk = ~clk;

  // The two instances share all inputs: one is MSB-first, the other LSB-first.
  byte_packer #(.BYTE_W(BYTE_W), .MSB_FIRST(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef BYTE_PACKER_FLUSH_EN
    , .flush(flush), .out_bytes(out_bytes)
`endif
  );

  byte_packer #(.BYTE_W(BYTE_W), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_l), .out_data(out_data_l), .out_valid(out_valid_l),
    .out_ready(out_ready)
`ifdef BYTE_PACKER_FLUSH_EN
    , .flush(flush), .out_bytes(out_bytes_l)
`endif
  );

  // ---------------------------------------------------------------- scoreboard
  int checks = 0;
  int failures = 0;

  logic [WORD_W-1:0] exp_q[$];    // expected words, in MSB-first form
  logic [2:0]        expb_q[$];   // expected byte count for each word
  logic [BYTE_W-1:0] part_q[$];   // bytes accepted toward the next word
  bit                flush_pend_m = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bytes in arrival order, with the first byte in the top lane and unused
  // lanes set to zero.
  function automatic logic [WORD_W-1:0] pack_msb(input logic [BYTE_W-1:0] b[$]);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int i = 0; i < b.size(); i++) w[(3-i)*BYTE_W +: BYTE_W] = b[i];
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] swap_bytes(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    for (int i = 0; i < 4; i++) r[i*BYTE_W +: BYTE_W] = w[(3-i)*BYTE_W +: BYTE_W];
    return r;
  endfunction

  // The only stall is a fourth byte (or a flush) that finds the output
  // buffer occupied and not being drained.
  function automatic bit exp_in_ready();
    bit buf_free;
    bit r;
    buf_free = (exp_q.size() == 0) || out_ready;
    r = (part_q.size() != 3) || buf_free;
`ifdef BYTE_PACKER_FLUSH_EN
    if ((flush || flush_pend_m) && part_q.size() > 0 && !buf_free) r = 1'b0;
`endif
    return r;
  endfunction

  // Monitor: compares outputs at the negedge and pops completed words.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid_lsb", out_valid_l, 0);
      check("rst_out_data_lsb", out_data_l, 0);
`ifdef BYTE_PACKER_FLUSH_EN
      check("rst_out_bytes", out_bytes, 0);
`endif
    end else begin
      check("out_valid", out_valid, exp_q.size() != 0);
      check("out_valid_lsb", out_valid_l, exp_q.size() != 0);
      check("in_ready", in_ready, exp_in_ready());
      check("in_ready_lsb", in_ready_l, exp_in_ready());
      if (out_valid && exp_q.size() != 0) begin
        check("out_data", out_data, exp_q[0]);
        check("out_data_lsb", out_data_l, swap_bytes(exp_q[0]));
`ifdef BYTE_PACKER_FLUSH_EN
        check("out_bytes", out_bytes, expb_q[0]);
        check("out_bytes_lsb", out_bytes_l, expb_q[0]);
`endif
        if (out_ready) begin
          void'(exp_q.pop_front());
          void'(expb_q.pop_front());
        end
      end
    end
  end

  // Reference model: gathers accepted bytes and pushes a word once four have
  // arrived (or when a flush is honoured).
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        exp_q.delete();
        expb_q.delete();
        part_q.delete();
        flush_pend_m = 1'b0;
      end else begin
        bit buf_free;
        bit freq;
        buf_free = (exp_q.size() == 0) || out_ready;
        freq = 1'b0;
`ifdef BYTE_PACKER_FLUSH_EN
        freq = flush || flush_pend_m;
`endif
        if (in_valid && exp_in_ready()) part_q.push_back(in_data);
        if (part_q.size() == 4 || (freq && part_q.size() > 0 && buf_free)) begin
          exp_q.push_back(pack_msb(part_q));
          expb_q.push_back(3'(part_q.size()));
          part_q.delete();
          flush_pend_m = 1'b0;
        end else if (freq && part_q.size() > 0) begin
          flush_pend_m = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one byte and holds it until it is accepted, up to a 50-cycle bound.
  task automatic send_byte(input logic [BYTE_W-1:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 expected in_ready=1 within 50 cycles");
    end
    tick();
    in_valid = 1'b0;
    in_data  = BYTE_W'($urandom);
  endtask

  initial begin : main
    logic [BYTE_W-1:0] stall_bytes[8];
    int n;
    for (int i = 0; i < 8; i++) stall_bytes[i] = BYTE_W'(i + 1);

    // Reset is held for three cycles.
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // First word, with the consumer always ready.
    out_ready = 1'b1;
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    @(negedge clk);
    check("t1_word", out_data, 32'h12345678);
    check("t1_word_lsb", out_data_l, 32'h78563412);
    check("t1_valid", out_valid, 1);
    tick();
    @(negedge clk);
    check("t1_valid_drop", out_valid, 0);
    tick();

    // Eight back-to-back bytes.
    for (int i = 0; i < 8; i++) send_byte(stall_bytes[i]);
    repeat (3) tick();

    // Consumer stalls. Bytes 5-7 go in; byte 8 waits; then the words swap.
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) send_byte(stall_bytes[i]);
    in_valid = 1'b1;
    in_data  = stall_bytes[7];
    repeat (3) begin
      @(negedge clk);
      check("t3_stall_ready", in_ready, 0);
      check("t3_hold_word", out_data, 32'h01020304);
    end
    tick();
    out_ready = 1'b1;
    send_byte(stall_bytes[7]);
    @(negedge clk);
    check("t3_swap_word", out_data, 32'h05060708);
    check("t3_swap_valid", out_valid, 1);
    tick();

    // Reset mid-word drops the partial bytes.
    send_byte(8'hE1); send_byte(8'hE2);
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    @(negedge clk);
    check("t5_word", out_data, 32'h11223344);
    check("t5_word_lsb", out_data_l, 32'h44332211);
    tick();

`ifdef BYTE_PACKER_FLUSH_EN
    // A partial word is flushed, then a full word follows.
    send_byte(8'h9A); send_byte(8'hBC);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("fl_word", out_data, 32'h9ABC0000);
    check("fl_bytes", out_bytes, 2);
    tick();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    @(negedge clk);
    check("fl_full_bytes", out_bytes, 4);
    tick();
    // A flush is blocked while an older word is pending.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(stall_bytes[i]);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1;
    repeat (4) tick();
`endif

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = BYTE_W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef BYTE_PACKER_FLUSH_EN
      flush     = ($urandom_range(0, 15) == 0);
`endif
      tick();
    end

    // Drain the remaining words.
    in_valid  = 1'b0;
    out_ready = 1'b1;
`ifdef BYTE_PACKER_FLUSH_EN
    flush     = 1'b0;
`endif
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    tick();
    check("drain_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule
